kufpu_iter: RTL

Iterative k-select unary filter unit: the time-multiplexed, runtime-configurable successor to the unrolled K-stage kufpu chain. It reuses one `ufpu` instance up to `K_MAX` times on a single request. Each pass selects entries from the remaining bit vector, accumulates them into the result and masks them out of the next pass. It sits in a Cell in place of a kufpu and feeds `bfpu` inputs unchanged, but adds a valid/ready request handshake, a per-request depth `k` and a selected-pass count.

---
 rtl/thanos_pkg.sv | 25 ++
 rtl/ufpu.sv | 75 +++++++
 rtl/kufpu_iter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/thanos_pkg.sv
// Shared Thanos cell definitions: vector geometry, ufpu opcodes and the
// request-capture record used by the iterative k-select filter.
package thanos_pkg;

    localparam int BIT_VEC_SIZE       = 128;
    localparam int BIT_VEC_SIZE_LOG   = $clog2(BIT_VEC_SIZE);
    localparam int NUM_OF_METRICS     = 8;
    localparam int NUM_OF_METRICS_LOG = $clog2(NUM_OF_METRICS);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LSB  = 3'd1,
        OP_ID   = 3'd2,
        OP_PRED = 3'd3
    } opcode_t;

    typedef struct packed {
        opcode_t                       opcode;
        logic [BIT_VEC_SIZE_LOG-1:0]   id;
        logic [NUM_OF_METRICS_LOG-1:0] metric_x;
        logic [15:0]                   val;
        logic [2:0]                    pred_op;
    } req_t;

endpackage

// File: rtl/ufpu.sv
// Unary filter processing unit: two-stage pipeline that selects entries of
// the candidate vector according to the opcode (result valid 2 cycles after valid_in).
module ufpu
    import thanos_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BIT_VEC_SIZE-1:0]       in,
    input  logic                          valid_in,
    input  logic [2:0]                    opcode,
    input  logic [BIT_VEC_SIZE_LOG-1:0]   id,
    input  logic [NUM_OF_METRICS_LOG-1:0] metricX,
    input  logic [15:0]                   val,
    input  logic [2:0]                    pred_op,
    output logic [BIT_VEC_SIZE-1:0]       out
);

    logic                          s1_v;
    logic [BIT_VEC_SIZE-1:0]       s1_in;
    opcode_t                       s1_op;
    logic [BIT_VEC_SIZE_LOG-1:0]   s1_id;
    logic [NUM_OF_METRICS_LOG-1:0] s1_metric;
    logic [15:0]                   s1_val;
    logic [2:0]                    s1_pred;

    logic [BIT_VEC_SIZE-1:0] lsb;
    logic [BIT_VEC_SIZE-1:0] res;
    logic [15:0]             thr;
    logic                    pred_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_in     <= '0;
            s1_op     <= OP_NOP;
            s1_id     <= '0;
            s1_metric <= '0;
            s1_val    <= '0;
            s1_pred   <= '0;
            out       <= '0;
        end else begin
            s1_v      <= valid_in;
            s1_in     <= valid_in ? in : '0;
            s1_op     <= opcode_t'(opcode);
            s1_id     <= id;
            s1_metric <= metricX;
            s1_val    <= val;
            s1_pred   <= pred_op;
            out       <= s1_v ? res : '0;
        end
    end

    // Predicate compares the request value against the metric index as threshold.
    always_comb begin
        lsb     = s1_in & (~s1_in + 1'b1);
        thr     = 16'(s1_metric);
        pred_ok = 1'b1;
        case (s1_pred)
            3'd0:    pred_ok = (s1_val == thr);
            3'd1:    pred_ok = (s1_val != thr);
            3'd2:    pred_ok = (s1_val <  thr);
            3'd3:    pred_ok = (s1_val <= thr);
            3'd4:    pred_ok = (s1_val >  thr);
            3'd5:    pred_ok = (s1_val >= thr);
            default: pred_ok = 1'b1;
        endcase
        case (s1_op)
            OP_LSB:  res = lsb;
            OP_ID:   res = s1_in & (BIT_VEC_SIZE'(1) << s1_id);
            OP_PRED: res = pred_ok ? lsb : '0;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/kufpu_iter.sv
// Iterative k-select unary filter: reuses one ufpu up to K_MAX passes per request.
// Optional early termination when the vector empties: define KUFPU_ITER_EARLY_EXIT_EN.
module kufpu_iter
    import thanos_pkg::*;
#(
    parameter int K_MAX    = 4,
    parameter int UFPU_LAT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BIT_VEC_SIZE-1:0]       in,
    input  logic                          valid_in,
    output logic                          ready,
    input  logic [2:0]                    opcode,
    input  logic [BIT_VEC_SIZE_LOG-1:0]   id,
    input  logic [NUM_OF_METRICS_LOG-1:0] metricX,
    input  logic [15:0]                   val,
    input  logic [2:0]                    pred_op,
    input  logic [$clog2(K_MAX+1)-1:0]    k_in,
    output logic [BIT_VEC_SIZE-1:0]       out,
    output logic                          valid_out,
    output logic [$clog2(K_MAX+1)-1:0]    count_out
);

    localparam int KW = $clog2(K_MAX + 1);
    localparam int CW = $clog2(UFPU_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                  state;
    req_t                    req;
    logic [BIT_VEC_SIZE-1:0] remaining;
    logic [BIT_VEC_SIZE-1:0] acc;
    logic [KW-1:0]           iter;
    logic [KW-1:0]           k;
    logic [KW-1:0]           sel_cnt;
    logic [CW-1:0]           wcnt;
    logic                    issue;

    logic [BIT_VEC_SIZE-1:0] sel;
    logic [BIT_VEC_SIZE-1:0] rem_next;
    logic [KW-1:0]           iter_next;
    logic [KW-1:0]           k_clamped;
    logic                    zero_work;
    logic                    finish;

    ufpu u_ufpu (
        .clk      (clk),
        .rst      (rst),
        .in       (remaining),
        .valid_in (issue),
        .opcode   (req.opcode),
        .id       (req.id),
        .metricX  (req.metric_x),
        .val      (req.val),
        .pred_op  (req.pred_op),
        .out      (sel)
    );

    always_comb begin
        rem_next  = remaining & ~sel;
        iter_next = iter + 1'b1;
        k_clamped = (k_in > KW'(K_MAX)) ? KW'(K_MAX) : k_in;
        zero_work = (opcode_t'(opcode) == OP_NOP) || (k_clamped == '0);
        finish    = (iter_next == k);
`ifdef KUFPU_ITER_EARLY_EXIT_EN
        finish    = finish || (rem_next == '0) || (sel == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            req       <= '0;
            remaining <= '0;
            acc       <= '0;
            iter      <= '0;
            k         <= '0;
            sel_cnt   <= '0;
            wcnt      <= '0;
            issue     <= 1'b0;
            ready     <= 1'b1;
            out       <= '0;
            valid_out <= 1'b0;
            count_out <= '0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_in) begin
                        req.opcode   <= opcode_t'(opcode);
                        req.id       <= id;
                        req.metric_x <= metricX;
                        req.val      <= val;
                        req.pred_op  <= pred_op;
                        remaining    <= in;
                        acc          <= '0;
                        iter         <= '0;
                        sel_cnt      <= '0;
                        k            <= k_clamped;
                        ready        <= 1'b0;
                        if (zero_work) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_ISSUE;
                            issue <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    issue <= 1'b0;
                    wcnt  <= CW'(UFPU_LAT);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    wcnt <= wcnt - 1'b1;
                    // Counter reaches zero on this edge: the ufpu result is current.
                    if (wcnt == CW'(1)) begin
                        acc       <= acc | sel;
                        remaining <= rem_next;
                        iter      <= iter_next;
                        sel_cnt   <= sel_cnt + KW'(sel != '0);
                        if (finish) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_ISSUE;
                            issue <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    out       <= acc;
                    count_out <= sel_cnt;
                    valid_out <= 1'b1;
                    ready     <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
